pipelined_carry_adder: RTL



---
 rtl/pipelined_carry_adder.sv | 85 ++++++++
 1 files changed

// File: rtl/pipelined_carry_adder.sv
// pipelined_carry_adder: WIDTH-bit add/sub, SEG bits per stage, valid/ready with global stall, registered cout/ovf/zero
module pipelined_carry_adder #(
  parameter int WIDTH = 16,
  parameter int SEG = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int STAGES = WIDTH / SEG;
  localparam int L = STAGES - 1;
  logic [WIDTH-1:0] ra [STAGES];
  logic [WIDTH-1:0] rb [STAGES];
  logic [WIDTH-1:0] rs [STAGES];
  logic [WIDTH-1:0] ia [STAGES];
  logic [WIDTH-1:0] ib [STAGES];
  logic [WIDTH-1:0] is [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [SEG:0] ps [STAGES];
  logic rv [STAGES];
  logic rc [STAGES];
  logic iv [STAGES];
  logic ic [STAGES];
  logic nc [STAGES];
  logic stall;
  assign stall = out_valid && !out_ready;
  assign in_ready = !stall;
  assign out_valid = rv[L];
  assign sum = rs[L];
  assign cout = rc[L];
  always_comb begin
    ia[0] = a;
    ib[0] = sub ? ~b : b;
    is[0] = '0;
    ic[0] = sub ? ~cin : cin;
    iv[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      ia[k] = ra[k-1];
      ib[k] = rb[k-1];
      is[k] = rs[k-1];
      ic[k] = rc[k-1];
      iv[k] = rv[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      ps[k] = {1'b0, ia[k][k*SEG +: SEG]} + {1'b0, ib[k][k*SEG +: SEG]} + (SEG+1)'(ic[k]);
      ns[k] = is[k];
      ns[k][k*SEG +: SEG] = ps[k][SEG-1:0];
      nc[k] = ps[k][SEG];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        rv[k] <= 1'b0;
        rc[k] <= 1'b0;
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
      end
      ovf <= 1'b0;
      zero <= 1'b0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        rv[k] <= iv[k];
        rc[k] <= nc[k];
        ra[k] <= ia[k];
        rb[k] <= ib[k];
        rs[k] <= ns[k];
      end
      ovf <= (ia[L][WIDTH-1] == ib[L][WIDTH-1]) && (ns[L][WIDTH-1] != ia[L][WIDTH-1]);
      zero <= ns[L] == '0;
    end
  end
endmodule
